// File: rtl/ts_pair_scheduler_pkg.sv
// Shared definitions for the tracklet-search pair scheduler: default widths,
// count-word field layout and FSM state encoding.
package ts_pair_scheduler_pkg;

   localparam int unsigned DefAdrW = 6;
   localparam int unsigned DefBxW  = 8;

   // Count word layout is {bx, in_cnt, out_cnt}, MSB first.
   localparam int unsigned OutCntLsb = 0;

   function automatic int unsigned in_cnt_lsb(input int unsigned adr_w);
      return adr_w;
   endfunction

   function automatic int unsigned bx_lsb(input int unsigned adr_w);
      return 2 * adr_w;
   endfunction

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLoad,
      StScan,
      StDone
   } state_e;

endpackage

// File: rtl/ts_pair_counter.sv
// Nested 2-D stub address counter: outer address runs fastest, inner address
// steps when the outer one wraps. Flags the final (in_cnt-1, out_cnt-1) pair.
module ts_pair_counter
   import ts_pair_scheduler_pkg::*;
#(
   parameter int unsigned ADR_W = DefAdrW
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [ADR_W-1:0] in_cnt_i,
   input  logic [ADR_W-1:0] out_cnt_i,
   input  logic             advance_i,
   output logic [ADR_W-1:0] in_adr_o,
   output logic [ADR_W-1:0] out_adr_o,
   output logic             last_pair_o
);

   logic [ADR_W-1:0] in_adr_q, out_adr_q;
   // Terminal addresses are stored as count-1 so a full 2^ADR_W-1 count never wraps.
   logic [ADR_W-1:0] in_max_q, out_max_q;

   // Load zeroes the addresses and latches terminals; advance steps outer-first.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         in_adr_q  <= '0;
         out_adr_q <= '0;
         in_max_q  <= '0;
         out_max_q <= '0;
      end else if (load_i) begin
         in_adr_q  <= '0;
         out_adr_q <= '0;
         in_max_q  <= in_cnt_i - 1'b1;
         out_max_q <= out_cnt_i - 1'b1;
      end else if (advance_i) begin
         if (out_adr_q == out_max_q) begin
            out_adr_q <= '0;
            in_adr_q  <= in_adr_q + 1'b1;
         end else begin
            out_adr_q <= out_adr_q + 1'b1;
         end
      end
   end

   assign in_adr_o    = in_adr_q;
   assign out_adr_o   = out_adr_q;
   assign last_pair_o = (in_adr_q == in_max_q) && (out_adr_q == out_max_q);

endmodule

// File: rtl/ts_pair_scheduler.sv
// Per-crossing scheduler: pops a stub-count word, walks every inner/outer
// address pair with a valid/ready handshake, then pulses crossing_done.
module ts_pair_scheduler
   import ts_pair_scheduler_pkg::*;
#(
   parameter int unsigned ADR_W = DefAdrW,
   parameter int unsigned BX_W  = DefBxW,
   parameter int unsigned CNT_W = ADR_W + BX_W + ADR_W
) (
   input  logic             proc_clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             stub_cnt_fifo_empty,
   output logic             stub_cnt_fifo_rd_en,
   input  logic [CNT_W-1:0] struct_stub_cnt,
   output logic [ADR_W-1:0] in_stub_adr,
   output logic [ADR_W-1:0] out_stub_adr,
   output logic             mem_page,
   output logic             pair_valid,
   input  logic             pair_ready,
   output logic [BX_W-1:0]  crossing_bx,
   output logic             crossing_done,
   output logic             busy
);

   localparam int unsigned InLsb = in_cnt_lsb(ADR_W);
   localparam int unsigned BxLsb = bx_lsb(ADR_W);

   state_e          state_q;
   logic            rd_en_q, pair_valid_q, done_q, mem_page_q;
   logic [BX_W-1:0] bx_q;

   logic [ADR_W-1:0] word_in_cnt, word_out_cnt;
   logic [BX_W-1:0]  word_bx;
   logic             word_empty;
   logic             fetch_ok, accept, last_pair;

   assign word_out_cnt = struct_stub_cnt[OutCntLsb +: ADR_W];
   assign word_in_cnt  = struct_stub_cnt[InLsb +: ADR_W];
   assign word_bx      = struct_stub_cnt[BxLsb +: BX_W];
   assign word_empty   = (word_in_cnt == '0) || (word_out_cnt == '0);

   assign fetch_ok = enable && !stub_cnt_fifo_empty;
   // pair_ready is only meaningful while a pair is being offered.
   assign accept   = (state_q == StScan) && pair_valid_q && pair_ready;

   ts_pair_counter #(
      .ADR_W (ADR_W)
   ) u_counter (
      .clk_i       (proc_clk),
      .rst_ni      (reset),
      .load_i      ((state_q == StLoad) && !word_empty),
      .in_cnt_i    (word_in_cnt),
      .out_cnt_i   (word_out_cnt),
      .advance_i   (accept && !last_pair),
      .in_adr_o    (in_stub_adr),
      .out_adr_o   (out_stub_adr),
      .last_pair_o (last_pair)
   );

   // Crossing sequencer with registered strobes and handshake outputs.
   always_ff @(posedge proc_clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         rd_en_q      <= 1'b0;
         pair_valid_q <= 1'b0;
         done_q       <= 1'b0;
         mem_page_q   <= 1'b0;
         bx_q         <= '0;
      end else begin
         rd_en_q <= 1'b0;
         done_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (fetch_ok) begin
                  state_q <= StFetch;
                  rd_en_q <= 1'b1;
               end
            end
            StFetch: state_q <= StLoad;
            StLoad: begin
               bx_q       <= word_bx;
               mem_page_q <= ~mem_page_q;
               if (word_empty) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end else begin
                  state_q      <= StScan;
                  pair_valid_q <= 1'b1;
               end
            end
            StScan: begin
               if (accept && last_pair) begin
                  state_q      <= StDone;
                  pair_valid_q <= 1'b0;
                  done_q       <= 1'b1;
               end
            end
            StDone: begin
               if (fetch_ok) begin
                  state_q <= StFetch;
                  rd_en_q <= 1'b1;
               end else begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign stub_cnt_fifo_rd_en = rd_en_q;
   assign pair_valid          = pair_valid_q;
   assign crossing_done       = done_q;
   assign mem_page            = mem_page_q;
   assign crossing_bx         = bx_q;
   assign busy                = (state_q != StIdle);

endmodule

// File: tb/tb_ts_pair_scheduler.sv
// Directed bench for ts_pair_scheduler with a behavioural count FIFO.
module tb_ts_pair_scheduler;

   localparam int unsigned ADR_W = 6;
   localparam int unsigned BX_W  = 8;
   localparam int unsigned CNT_W = ADR_W + BX_W + ADR_W;

   logic             proc_clk = 1'b0;
   logic             reset = 1'b0;
   logic             enable = 1'b0;
   logic             stub_cnt_fifo_empty = 1'b1;
   logic             stub_cnt_fifo_rd_en;
   logic [CNT_W-1:0] struct_stub_cnt = '0;
   logic [ADR_W-1:0] in_stub_adr, out_stub_adr;
   logic             mem_page, pair_valid, crossing_done, busy;
   logic             pair_ready = 1'b0;
   logic [BX_W-1:0]  crossing_bx;

   ts_pair_scheduler #(
      .ADR_W (ADR_W),
      .BX_W  (BX_W),
      .CNT_W (CNT_W)
   ) dut (
      .proc_clk            (proc_clk),
      .reset               (reset),
      .enable              (enable),
      .stub_cnt_fifo_empty (stub_cnt_fifo_empty),
      .stub_cnt_fifo_rd_en (stub_cnt_fifo_rd_en),
      .struct_stub_cnt     (struct_stub_cnt),
      .in_stub_adr         (in_stub_adr),
      .out_stub_adr        (out_stub_adr),
      .mem_page            (mem_page),
      .pair_valid          (pair_valid),
      .pair_ready          (pair_ready),
      .crossing_bx         (crossing_bx),
      .crossing_done       (crossing_done),
      .busy                (busy)
   );

   always #5 proc_clk = ~proc_clk;

   logic [CNT_W-1:0]     fifo[$];
   logic [2*ADR_W-1:0]   acc[$];
   int                   n_cmp = 0, n_err = 0;
   int                   cyc = 0, rd_cnt = 0, rd_empty_err = 0, stall_err = 0, done_cnt = 0;
   logic [BX_W-1:0]      done_bx = '0;
   logic                 done_page = 1'b0;
   int                   t0, budget;
   int                   pat[7] = '{1, 0, 0, 1, 0, 1, 1};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CNT_W-1:0] pack(input int bx, input int ni, input int no);
      return {bx[BX_W-1:0], ni[ADR_W-1:0], no[ADR_W-1:0]};
   endfunction

   task automatic push(input logic [CNT_W-1:0] w);
      fifo.push_back(w);
      stub_cnt_fifo_empty = 1'b0;
   endtask

   task automatic clear_logs();
      acc.delete();
      rd_cnt = 0; rd_empty_err = 0; stall_err = 0; done_cnt = 0;
   endtask

   // One clock: models the FIFO pop, logs handshakes and checks stall stability.
   task automatic tick();
      logic rd, v, r, rst;
      logic [ADR_W-1:0] ia, oa;
      rd = stub_cnt_fifo_rd_en; v = pair_valid; r = pair_ready; rst = reset;
      ia = in_stub_adr; oa = out_stub_adr;
      @(posedge proc_clk);
      #1;
      cyc++;
      if (rd) begin
         rd_cnt++;
         if (fifo.size() > 0) struct_stub_cnt = fifo.pop_front();
         else rd_empty_err++;
      end
      stub_cnt_fifo_empty = (fifo.size() == 0);
      if (rst && v && r) acc.push_back({ia, oa});
      if (rst && reset && v && !r)
         if (!(pair_valid && in_stub_adr == ia && out_stub_adr == oa)) stall_err++;
      if (crossing_done) begin
         done_cnt++;
         done_bx   = crossing_bx;
         done_page = mem_page;
      end
   endtask

   task automatic wait_done(input int max_cyc, input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!crossing_done && n < max_cyc);
      check(tag, {31'd0, crossing_done}, 32'd1);
   endtask

   task automatic wait_valid(input int max_cyc, input string tag);
      int n = 0;
      while (!pair_valid && n < max_cyc) begin
         tick();
         n++;
      end
      check(tag, {31'd0, pair_valid}, 32'd1);
   endtask

   // Expected order: outer index fastest.
   task automatic check_log(input string tag, input int ni, input int no);
      int bad = 0;
      logic [2*ADR_W-1:0] e;
      check({tag, "_cnt"}, acc.size(), ni * no);
      if (acc.size() != ni * no) bad = 1;
      else
         for (int i = 0; i < ni; i++)
            for (int o = 0; o < no; o++) begin
               e = {ADR_W'(i), ADR_W'(o)};
               if (acc[i * no + o] !== e) bad++;
            end
      check({tag, "_order"}, bad, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_en"}, {31'd0, stub_cnt_fifo_rd_en}, 0);
      check({tag, "_in_adr"}, {26'd0, in_stub_adr}, 0);
      check({tag, "_out_adr"}, {26'd0, out_stub_adr}, 0);
      check({tag, "_mem_page"}, {31'd0, mem_page}, 0);
      check({tag, "_valid"}, {31'd0, pair_valid}, 0);
      check({tag, "_bx"}, {24'd0, crossing_bx}, 0);
      check({tag, "_done"}, {31'd0, crossing_done}, 0);
      check({tag, "_busy"}, {31'd0, busy}, 0);
   endtask

   initial begin
      // Reset state.
      repeat (3) tick();
      check_all_zero("t0");
      reset = 1'b1;
      tick();

      // 2x3 crossing with ready held high.
      clear_logs();
      enable = 1'b1;
      pair_ready = 1'b1;
      push(pack(8'h12, 2, 3));
      t0 = cyc;
      wait_done(40, "t1_done");
      check("t1_latency", cyc - t0, 9);
      check("t1_rd_cnt", rd_cnt, 1);
      check("t1_bx", {24'd0, done_bx}, 32'h12);
      check("t1_page", {31'd0, done_page}, 1);
      check_log("t1_pairs", 2, 3);
      tick();
      check("t1_idle", {31'd0, busy}, 0);

      // Empty crossing followed by a 1x1 crossing, back to back.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      clear_logs();
      push(pack(1, 0, 4));
      push(pack(2, 1, 1));
      wait_done(20, "t2_done_a");
      check("t2_bx_a", {24'd0, done_bx}, 1);
      check("t2_page_a", {31'd0, done_page}, 1);
      check("t2_no_pairs", acc.size(), 0);
      tick();
      check("t2_refetch", {31'd0, stub_cnt_fifo_rd_en}, 1);
      wait_done(20, "t2_done_b");
      check("t2_bx_b", {24'd0, done_bx}, 2);
      check("t2_page_b", {31'd0, done_page}, 0);
      check_log("t2_pairs", 1, 1);
      check("t2_rd_cnt", rd_cnt, 2);
      tick();

      // Back-pressure: 2x2 with a ready pattern containing stalls.
      clear_logs();
      pair_ready = 1'b0;
      push(pack(3, 2, 2));
      wait_valid(10, "t3_valid");
      for (int k = 0; k < 7; k++) begin
         pair_ready = pat[k][0];
         tick();
      end
      check("t3_done", {31'd0, crossing_done}, 1);
      check("t3_done_cnt", done_cnt, 1);
      check("t3_stall", stall_err, 0);
      check_log("t3_pairs", 2, 2);
      pair_ready = 1'b0;
      tick();

      // Maximum counts with random ready.
      clear_logs();
      push(pack(4, 63, 63));
      budget = 0;
      do begin
         pair_ready = 1'($urandom_range(0, 1));
         tick();
         budget++;
      end while (!crossing_done && budget < 30000);
      check("t4_done", {31'd0, crossing_done}, 1);
      check_log("t4_pairs", 63, 63);
      if (acc.size() > 0) check("t4_last", {20'd0, acc[$]}, {20'd0, 6'd62, 6'd62});
      check("t4_done_cnt", done_cnt, 1);
      check("t4_stall", stall_err, 0);
      tick();

      // enable low blocks fetch; dropping it mid-scan lets the crossing finish.
      clear_logs();
      enable = 1'b0;
      pair_ready = 1'b1;
      push(pack(5, 2, 2));
      repeat (10) tick();
      check("t5_no_rd", rd_cnt, 0);
      check("t5_not_busy", {31'd0, busy}, 0);
      enable = 1'b1;
      wait_valid(10, "t5_valid");
      enable = 1'b0;
      push(pack(6, 3, 3));
      wait_done(20, "t5_done");
      check("t5_bx", {24'd0, done_bx}, 5);
      check_log("t5_pairs", 2, 2);
      repeat (3) tick();
      check("t5_idle", {31'd0, busy}, 0);
      check("t5_rd_cnt", rd_cnt, 1);

      // Reset mid-scan abandons the crossing; a later one restarts from (0,0).
      clear_logs();
      enable = 1'b1;
      wait_valid(10, "t6_valid");
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check_all_zero("t6_rst");
      reset = 1'b1;
      enable = 1'b0;
      repeat (3) tick();
      check("t6_no_done", done_cnt, 0);
      clear_logs();
      push(pack(7, 2, 1));
      enable = 1'b1;
      wait_done(20, "t6_done");
      check("t6_bx", {24'd0, done_bx}, 7);
      check("t6_page", {31'd0, done_page}, 1);
      check_log("t6_pairs", 2, 1);
      check("t6_rd_empty", rd_empty_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ts_pair_scheduler.md
Name: ts_pair_scheduler

Overview:
Sequences the tracklet search datapath for one inner/outer module pair. It pops per-crossing stub counts from the stub tagging count FIFO. It then walks every (inner stub, outer stub) address pair for that crossing with a valid/ready handshake toward the tracklet search logic, and signals end of crossing. It sits between the stub tagging block outputs (struct_stub_cnt, stub_cnt_fifo_*) and the in_stub_adr/out_stub_adr inputs of the tracklet search block.

Parameters:
ADR_W, 6, stub memory address width per layer (max stubs per crossing = 2^ADR_W - 1)
BX_W, 8, crossing number width
CNT_W, ADR_W+BX_W+ADR_W, packed count word width {bx, in_cnt, out_cnt}, MSB first

Ports:
proc_clk  in  1  processing clock
reset  in  1  synchronous reset, active-low
enable  in  1  when low, no new crossing is fetched; the crossing in progress completes
stub_cnt_fifo_empty  in  1  count FIFO empty flag
stub_cnt_fifo_rd_en  out  1  count FIFO read strobe, single-cycle pulse
struct_stub_cnt  in  CNT_W  FIFO read data, valid the cycle after rd_en
in_stub_adr  out  ADR_W  inner layer stub address of current pair
out_stub_adr  out  ADR_W  outer layer stub address of current pair
mem_page  out  1  stub memory page of current crossing, toggles per crossing
pair_valid  out  1  in/out address pair valid
pair_ready  in  1  tracklet search accepts pair
crossing_bx  out  BX_W  crossing number of crossing in progress
crossing_done  out  1  one-cycle pulse, all pairs of crossing accepted (or none existed)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0 at a proc_clk edge): state=IDLE. All outputs 0, including addresses, mem_page, crossing_bx, busy, and rd_en. Reset mid-crossing abandons the crossing; no crossing_done is emitted.
- States: IDLE, FETCH, LOAD, SCAN, DONE.
- IDLE: if enable & !stub_cnt_fifo_empty -> FETCH.
- FETCH: stub_cnt_fifo_rd_en=1 for exactly this cycle -> LOAD.
- LOAD: capture bx, in_cnt, out_cnt from struct_stub_cnt; crossing_bx<=bx; toggle mem_page.
  - If in_cnt==0 or out_cnt==0 -> DONE, with no pair_valid.
  - Otherwise in_stub_adr<=0, out_stub_adr<=0 -> SCAN.
- SCAN: pair_valid=1.
  - While pair_valid & !pair_ready, addresses and pair_valid must hold stable.
  - On pair_valid & pair_ready: if out_stub_adr==out_cnt-1 then out_stub_adr<=0 and in_stub_adr++; otherwise out_stub_adr++. Outer index is fastest.
  - Acceptance of pair (in_cnt-1, out_cnt-1) -> DONE; pair_valid deasserts the next cycle.
  - Maximum throughput is one pair per cycle when pair_ready is held high.
- DONE: crossing_done=1 for one cycle; crossing_bx held.
  - If enable & !empty -> FETCH directly; otherwise -> IDLE.
- Latency:
  - FIFO non-empty in IDLE -> rd_en at +1 cycle.
  - First pair_valid at +3 cycles.
  - Crossing of N pairs with ready tied high: IDLE-exit to crossing_done = N+3 cycles.
- Pair count is in_cnt*out_cnt. There are no multipliers; counters only.
- Counts of 2^ADR_W-1 are legal; counters must not wrap before the terminal comparison.
- enable dropping during SCAN has no effect until DONE.
- rd_en is never asserted when stub_cnt_fifo_empty is high. It is never asserted outside FETCH.
- pair_ready while pair_valid is low is ignored.

Decomposition:
- Shared package: ADR_W, BX_W defaults; the packed count-word field offsets (bx/in_cnt/out_cnt); the state encoding.
- One natural sub-module: ts_pair_counter. It holds the 2-D nested address counter with load, advance, and last-pair flag. The FSM stays in the top module.

Test Plan:
- FIFO holds {bx=0x12, in=2, out=3}, ready=1 -> rd_en once; pairs (0,0)(0,1)(0,2)(1,0)(1,1)(1,2) on consecutive cycles; crossing_done with crossing_bx=0x12 exactly 9 cycles after leaving IDLE; mem_page=1.
- Words {bx=1,in=0,out=4} then {bx=2,in=1,out=1} -> no pair_valid for bx=1 and crossing_done pulse; bx=2 emits single pair (0,0); mem_page sequence 1,0; DONE goes straight to FETCH.
- in=2,out=2, pair_ready toggled 1,0,0,1,0,1,1 -> addresses and valid stable during stalls; exactly 4 acceptances in order, no duplicates or skips.
- in=63,out=63 with ADR_W=6, random ready -> 3969 accepted pairs; last pair (62,62); single crossing_done.
- enable=0 with FIFO non-empty -> rd_en never asserts, busy=0; enable dropped mid-SCAN -> crossing completes then IDLE.
- reset driven low mid-SCAN for one cycle -> next cycle all outputs 0, state IDLE, no crossing_done; a later crossing processes normally from (0,0).
